// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into 16 48-bit round subkeys (K1..K16 or K16..K1).
// Latency: start at cycle T -> first subkey valid at T+2, one subkey per accepted transfer.
// Backpressure: subkey/round/C/D hold while subkey_ready is low; valid never drops without a transfer.
// Optional: define DES_KEY_PARITY_CHECK_EN to reject keys whose bytes fail odd parity (key_err pulse).
module des_key_schedule (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [63:0] key,
  input  logic        start,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        last,
  output logic        busy,
  output logic        key_err
);

  typedef enum logic [1:0] {IDLE, LOAD, GEN} state_t;

  // PC-1: DES input bit numbers (1 = key[63]) for C0 then D0
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: CD bit numbers (1 = C[27]) for subkey bits 1..48
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [27:0] c_reg;
  logic [27:0] d_reg;
  logic [3:0]  round_reg;
  logic        dec_reg;
  logic        parity_ok;
  logic        transfer;
  logic        shift_one;
  logic        accept_start;

`ifdef DES_KEY_PARITY_CHECK_EN
  // Every key byte must carry odd parity
  always_comb begin
    parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      parity_ok = parity_ok & (^key[8*b +: 8]);
    end
  end

  // One-cycle error pulse for a start rejected on parity
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      key_err <= 1'b0;
    end else begin
      key_err <= (state == IDLE) && start && !parity_ok;
    end
  end
`else
  assign parity_ok = 1'b1;
  assign key_err   = 1'b0;
`endif

  assign accept_start = (state == IDLE) && start && parity_ok;
  assign transfer     = (state == GEN) && subkey_ready;
  // The next subkey index is round+2; single shifts fall on indices 2, 9 and 16 in
  // either direction (decrypt walks the same shift table mirrored), i.e. round 0, 7, 14.
  assign shift_one    = (round_reg == 4'd0) || (round_reg == 4'd7) || (round_reg == 4'd14);

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_start) state_nxt = LOAD;
      LOAD:    state_nxt = GEN;
      GEN:     if (transfer && (round_reg == 4'd15)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // C/D rotation registers, round counter and latched direction
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      c_reg     <= '0;
      d_reg     <= '0;
      round_reg <= '0;
      dec_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_start) begin
            dec_reg        <= decrypt;
            {c_reg, d_reg} <= pc1_perm(key);
          end
        end
        LOAD: begin
          round_reg <= '0;
          // Decrypt starts from K16, which uses C0/D0 unshifted (28 total shifts)
          if (!dec_reg) begin
            c_reg <= rotl(c_reg, 1'b0);
            d_reg <= rotl(d_reg, 1'b0);
          end
        end
        GEN: begin
          if (transfer) begin
            if (round_reg == 4'd15) begin
              round_reg <= '0;
            end else begin
              round_reg <= round_reg + 4'd1;
              if (dec_reg) begin
                c_reg <= rotr(c_reg, !shift_one);
                d_reg <= rotr(d_reg, !shift_one);
              end else begin
                c_reg <= rotl(c_reg, !shift_one);
                d_reg <= rotl(d_reg, !shift_one);
              end
            end
          end
        end
        default: begin
          round_reg <= '0;
        end
      endcase
    end
  end

  assign subkey_valid = (state == GEN);
  assign subkey       = subkey_valid ? pc2_perm({c_reg, d_reg}) : '0;
  assign round        = round_reg;
  assign last         = subkey_valid && (round_reg == 4'd15);
  assign busy         = (state != IDLE);

endmodule
